// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   SERIAL_SUB_DEFAULT_WIDTH : default operand width
//   state_t                  : control FSM encoding (IDLE / RUN / DONE)
//   cnt_width()              : bit-counter width for a given operand width
// ----------------------------------------------------------------------------
package serial_sub_pkg;

   localparam int unsigned SERIAL_SUB_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must index bits 0..width-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
// Start/done handshake and operand/result bus of the serial subtractor.
//   start, a, b              : request and operands (master -> slave)
//   busy, done               : status (slave -> master)
//   diff, borrow_out         : result (slave -> master)
//   ovf                      : signed overflow, only with SERIAL_SUB_SIGNED_OVF_EN
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = serial_sub_pkg::SERIAL_SUB_DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, ovf
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );
`endif

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor cell: computes a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: a - b computed LSB-first, one bit per clock,
// through a single full_subtractor cell and a borrow flip-flop.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_subtractor_if.slave (start/a/b in, busy/done/diff/borrow_out out)
// Optional feature macro: SERIAL_SUB_SIGNED_OVF_EN adds the signed overflow
// output bus.ovf and the operand-MSB capture that feeds it.
// ----------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // Control
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_shift;
   logic             w_last;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             r_busy;
   logic             r_done;

   // Datapath
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;
   logic             w_d;
   logic             w_bout;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; start is only honoured in IDLE and DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = RUN;
         RUN:     if (r_cnt == LAST_BIT) w_state_nxt = DONE;
         DONE:    w_state_nxt = bus.start ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output/strobe decode; busy/done are registered from the next state
   always_comb begin
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_last  = 1'b0;
      case (r_state)
         IDLE: w_load = bus.start;
         RUN: begin
            w_shift = 1'b1;
            w_last  = (r_cnt == LAST_BIT);
         end
         DONE: w_load = bus.start;
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt == RUN);
      w_done_nxt = (w_state_nxt == DONE);
   end

   // Status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   // Shared arithmetic cell
   full_subtractor u_cell (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   // Operand shift registers, result register, borrow FF and bit counter.
   // The result fills from the MSB side, so after WIDTH shifts bit 0 sits at LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a      <= bus.a;
         r_b      <= bus.b;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_shift) begin
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_res    <= {w_d, r_res[WIDTH-1:1]};
         r_borrow <= w_bout;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   // Operand MSBs are captured at load because the shift registers lose them.
   // Overflow is resolved on the last bit, when w_d is the result MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_load) begin
         r_a_msb <= bus.a[WIDTH-1];
         r_b_msb <= bus.b[WIDTH-1];
      end else if (w_last) begin
         r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.diff       = r_res;
   assign bus.borrow_out = r_borrow;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8))  bus8 ();
   serial_subtractor_if #(.WIDTH(16)) bus16 ();

   serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   // Issue one op on the 8-bit instance from IDLE; n = negedges after the start
   // edge until done is seen (expected 8).
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic bo, output int n);
      @(negedge clk);
      bus8.a = a; bus8.b = b; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      n = 0;
      while (bus8.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      d  = bus8.diff;
      bo = bus8.borrow_out;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b diff=%h bo=%b, want all 0",
                  bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
      end
      checks++;
      if (dut8.r_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d want IDLE", dut8.r_state);
      end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      checks++;
      if (bus8.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: got %b want 0", bus8.ovf);
      end
`endif
      // Reset wins over a simultaneous start
      bus8.a = 8'h12; bus8.b = 8'h34; bus8.start = 1'b1;
      @(negedge clk);
      checks++;
      if (bus8.busy !== 1'b0 || dut8.r_state !== IDLE) begin
         errors++;
         $display("FAIL reset_vs_start: busy=%b state=%0d want 0/IDLE", bus8.busy, dut8.r_state);
      end
      bus8.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] d;
      logic       bo;
      int         n;
      // Check busy right after the start edge, then let the op finish
      @(negedge clk);
      bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy: busy=%b done=%b want 1/0", bus8.busy, bus8.done);
      end
      n = 0;
      while (bus8.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      d = bus8.diff; bo = bus8.borrow_out;
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL basic_latency: got %0d want 8", n);
      end
      checks++;
      if (d !== 8'h1E || bo !== 1'b0 || bus8.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_5A_3C: diff=%h bo=%b busy=%b want 1e/0/0", d, bo, bus8.busy);
      end
      @(negedge clk);
      checks++;
      if (bus8.done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width: done=%b want 0", bus8.done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus8.diff !== 8'h1E || bus8.borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL result_hold: diff=%h bo=%b want 1e/0", bus8.diff, bus8.borrow_out);
      end
   endtask

   task automatic test_borrow();
      logic [7:0] d;
      logic       bo;
      int         n;
      do_op8(8'h00, 8'h01, d, bo, n);
      checks++;
      if (d !== 8'hFF || bo !== 1'b1 || n !== 8) begin
         errors++;
         $display("FAIL borrow_00_01: diff=%h bo=%b n=%0d want ff/1/8", d, bo, n);
      end
      do_op8(8'h10, 8'h20, d, bo, n);
      checks++;
      if (d !== 8'hF0 || bo !== 1'b1 || n !== 8) begin
         errors++;
         $display("FAIL borrow_10_20: diff=%h bo=%b n=%0d want f0/1/8", d, bo, n);
      end
      do_op8(8'hFF, 8'hFF, d, bo, n);
      checks++;
      if (d !== 8'h00 || bo !== 1'b0) begin
         errors++;
         $display("FAIL equal_ff_ff: diff=%h bo=%b want 00/0", d, bo);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      bus8.a = 8'h33; bus8.b = 8'h11; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      n = 0;
      repeat (2) begin
         @(negedge clk);
         n++;
      end
      // Third RUN cycle: this start must be ignored
      bus8.a = 8'hFF; bus8.b = 8'h00; bus8.start = 1'b1;
      @(negedge clk);
      n++;
      bus8.start = 1'b0;
      while (bus8.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 8 || bus8.diff !== 8'h22 || bus8.borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL start_in_run_ignored: n=%0d diff=%h bo=%b want 8/22/0", n, bus8.diff, bus8.borrow_out);
      end
      // Start in the done cycle is accepted
      bus8.a = 8'h09; bus8.b = 8'h04; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1) begin
         errors++;
         $display("FAIL start_in_done_busy: busy=%b want 1", bus8.busy);
      end
      n = 0;
      while (bus8.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 8 || bus8.diff !== 8'h05 || bus8.borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL start_in_done: n=%0d diff=%h bo=%b want 8/05/0", n, bus8.diff, bus8.borrow_out);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      logic [7:0] d;
      logic       bo;
      int         n;
      int         seen;
      @(negedge clk);
      bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 ||
          bus8.borrow_out !== 1'b0 || dut8.r_state !== IDLE) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b done=%b diff=%h bo=%b state=%0d want 0/0/00/0/IDLE",
                  bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, dut8.r_state);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus8.done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midrun_no_done: done pulses=%0d want 0", seen);
      end
      do_op8(8'h09, 8'h04, d, bo, n);
      checks++;
      if (d !== 8'h05 || bo !== 1'b0 || n !== 8) begin
         errors++;
         $display("FAIL after_reset_op: diff=%h bo=%b n=%0d want 05/0/8", d, bo, n);
      end
   endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   task automatic test_ovf();
      logic [7:0] d;
      logic       bo;
      int         n;
      do_op8(8'h80, 8'h01, d, bo, n);
      checks++;
      if (d !== 8'h7F || bus8.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_80_01: diff=%h ovf=%b want 7f/1", d, bus8.ovf);
      end
      do_op8(8'h7F, 8'hFF, d, bo, n);
      checks++;
      if (d !== 8'h80 || bus8.ovf !== 1'b1 || bo !== 1'b1) begin
         errors++;
         $display("FAIL ovf_7F_FF: diff=%h ovf=%b bo=%b want 80/1/1", d, bus8.ovf, bo);
      end
      do_op8(8'h05, 8'h03, d, bo, n);
      checks++;
      if (d !== 8'h02 || bus8.ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_05_03: diff=%h ovf=%b want 02/0", d, bus8.ovf);
      end
   endtask
`endif

   // Random back-to-back ops on the 8-bit instance, start issued in every done cycle
   task automatic test_sweep8(input int ops);
      logic [7:0] ea, eb;
      int         n;
      @(negedge clk);
      ea = 8'($urandom); eb = 8'($urandom);
      bus8.a = ea; bus8.b = eb; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      for (int i = 0; i < ops; i++) begin
         n = 0;
         while (bus8.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n !== 8 || bus8.diff !== 8'(ea - eb) || bus8.borrow_out !== (ea < eb)) begin
            errors++;
            $display("FAIL sweep8[%0d] %h-%h: n=%0d diff=%h bo=%b want 8/%h/%b",
                     i, ea, eb, n, bus8.diff, bus8.borrow_out, 8'(ea - eb), (ea < eb));
         end
         ea = 8'($urandom); eb = 8'($urandom);
         bus8.a = ea; bus8.b = eb; bus8.start = (i < ops - 1);
         @(negedge clk);
         bus8.start = 1'b0;
      end
   endtask

   // Same as above on the 16-bit instance; done spacing is 17 cycles
   task automatic test_sweep16(input int ops);
      logic [15:0] ea, eb;
      int          n;
      @(negedge clk);
      ea = 16'($urandom); eb = 16'($urandom);
      bus16.a = ea; bus16.b = eb; bus16.start = 1'b1;
      @(negedge clk);
      bus16.start = 1'b0;
      for (int i = 0; i < ops; i++) begin
         n = 0;
         while (bus16.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n !== 16 || bus16.diff !== 16'(ea - eb) || bus16.borrow_out !== (ea < eb)) begin
            errors++;
            $display("FAIL sweep16[%0d] %h-%h: n=%0d diff=%h bo=%b want 16/%h/%b",
                     i, ea, eb, n, bus16.diff, bus16.borrow_out, 16'(ea - eb), (ea < eb));
         end
         ea = 16'($urandom); eb = 16'($urandom);
         bus16.a = ea; bus16.b = eb; bus16.start = (i < ops - 1);
         @(negedge clk);
         bus16.start = 1'b0;
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
      bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_borrow();
      test_back_to_back();
      test_reset_midrun();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      test_ovf();
`endif
      test_sweep8(1000);
      test_sweep16(300);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_subtractor
